// File: rtl/l2_home_responder.sv
// Purpose : home-side responder for the Spandex L2 request channel; serves ReqV/S/WT/O/WB/Odata
//           from a direct-mapped line store and answers on the L2 response-in channel.
// Latency : 2+RSP_LAT cycles from request handshake to first rsp_valid; one transaction in flight.
// Backpressure: req_ready only in IDLE; response fields held stable in SEND until rsp_ready.
// Ports   : clk/rst (async active-low); req_* request channel (valid/ready); rsp_* response
//           channel (valid/ready); busy is high whenever the FSM is outside IDLE.
module l2_home_responder #(
    parameter int LINE_ADDR_BITS = 28,
    parameter int WORDS_PER_LINE = 4,
    parameter int IDX_BITS       = 6,
    parameter int RSP_LAT        = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [2:0]                    req_coh_msg,
    input  logic [LINE_ADDR_BITS-1:0]     req_addr,
    input  logic [32*WORDS_PER_LINE-1:0]  req_line,
    input  logic [WORDS_PER_LINE-1:0]     req_word_mask,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [2:0]                    rsp_coh_msg,
    output logic [LINE_ADDR_BITS-1:0]     rsp_addr,
    output logic [32*WORDS_PER_LINE-1:0]  rsp_line,
    output logic [WORDS_PER_LINE-1:0]     rsp_word_mask,
    output logic                          busy
);
    localparam int LINE_BITS = 32 * WORDS_PER_LINE;
    localparam int TAG_BITS  = LINE_ADDR_BITS - IDX_BITS;
    localparam int ENTRIES   = 1 << IDX_BITS;
    localparam bit HAS_WAIT  = (RSP_LAT > 0);
    localparam logic [3:0] LAT_M1 = HAS_WAIT ? 4'(RSP_LAT - 1) : 4'd0;

    localparam logic [2:0] REQ_V = 3'd0, REQ_S = 3'd1, REQ_WT = 3'd2,
                           REQ_O = 3'd3, REQ_WB = 3'd4, REQ_ODATA = 3'd5;
    localparam logic [2:0] RSP_NACK = 3'd7;

    typedef enum logic [1:0] {IDLE, EXEC, WAIT, SEND} state_t;
    state_t state_q, state_d;

    logic [3:0]                wait_cnt_q;
    logic [2:0]                req_msg_q;
    logic [LINE_ADDR_BITS-1:0] req_addr_q;
    logic [LINE_BITS-1:0]      req_line_q;
    logic [WORDS_PER_LINE-1:0] req_mask_q;

    logic [ENTRIES-1:0]        valid_q;
    logic [ENTRIES-1:0]        owner_q;
    logic [TAG_BITS-1:0]       tag_q  [ENTRIES];
    logic [LINE_BITS-1:0]      data_q [ENTRIES];

    logic [IDX_BITS-1:0]       idx;
    logic [TAG_BITS-1:0]       tag;
    logic                      hit;
    logic [LINE_BITS-1:0]      hit_line;
    logic [LINE_BITS-1:0]      merged;
    logic                      is_write;
    logic                      exec;
    logic [2:0]                rsp_code;
    logic [LINE_BITS-1:0]      rsp_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (req_valid)         state_d = EXEC;
            EXEC: state_d = HAS_WAIT ? WAIT : SEND;
            WAIT: if (wait_cnt_q == 4'd0) state_d = SEND;
            SEND: if (rsp_ready)         state_d = IDLE;
            default:                     state_d = IDLE;
        endcase
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == SEND);
    assign busy      = (state_q != IDLE);
    assign exec      = (state_q == EXEC);

    // Store access, evaluated on the registered request during EXEC.
    always_comb begin
        idx      = req_addr_q[IDX_BITS-1:0];
        tag      = req_addr_q[LINE_ADDR_BITS-1:IDX_BITS];
        hit      = valid_q[idx] && (tag_q[idx] == tag);
        // A miss reads as zero, which also zero-fills unmasked words on write allocate.
        hit_line = hit ? data_q[idx] : '0;
        merged   = hit_line;
        for (int w = 0; w < WORDS_PER_LINE; w++) begin
            if (req_mask_q[w]) merged[32*w +: 32] = req_line_q[32*w +: 32];
        end
        is_write = (req_msg_q == REQ_WT) || (req_msg_q == REQ_WB);
        rsp_code = req_msg_q;
        rsp_data = '0;
        case (req_msg_q)
            REQ_V, REQ_S, REQ_ODATA: rsp_data = hit_line;
            REQ_WT, REQ_O, REQ_WB:   rsp_data = '0;
            default:                 rsp_code = RSP_NACK;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_msg_q     <= '0;
            req_addr_q    <= '0;
            req_line_q    <= '0;
            req_mask_q    <= '0;
            wait_cnt_q    <= '0;
            rsp_coh_msg   <= '0;
            rsp_addr      <= '0;
            rsp_line      <= '0;
            rsp_word_mask <= '0;
            valid_q       <= '0;
            owner_q       <= '0;
        end else begin
            if (req_valid && req_ready) begin
                req_msg_q  <= req_coh_msg;
                req_addr_q <= req_addr;
                req_line_q <= req_line;
                req_mask_q <= req_word_mask;
            end
            if (exec) begin
                wait_cnt_q    <= LAT_M1;
                rsp_coh_msg   <= rsp_code;
                rsp_addr      <= req_addr_q;
                rsp_line      <= rsp_data;
                rsp_word_mask <= req_mask_q;
                if (is_write) valid_q[idx] <= 1'b1;
                if (req_msg_q == REQ_O || req_msg_q == REQ_ODATA) owner_q[idx] <= 1'b1;
                if (req_msg_q == REQ_WB) owner_q[idx] <= 1'b0;
            end else if (state_q == WAIT && wait_cnt_q != 4'd0) begin
                wait_cnt_q <= wait_cnt_q - 4'd1;
            end
        end
    end

    // Line data and tags are deliberately not reset; clearing valid_q hides stale contents.
    always_ff @(posedge clk) begin
        if (exec && is_write) begin
            data_q[idx] <= merged;
            tag_q[idx]  <= tag;
        end
    end
endmodule

// File: tb/tb_l2_home_responder.sv
module tb_l2_home_responder;
    localparam int AW  = 28;
    localparam int WPL = 4;
    localparam int LB  = 32 * WPL;
    localparam int IB  = 6;
    localparam int RL  = 2;
    localparam int LAT = 2 + RL;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_ready;
    logic [2:0]    req_coh_msg;
    logic [AW-1:0] req_addr;
    logic [LB-1:0] req_line;
    logic [WPL-1:0] req_word_mask;
    logic          rsp_valid, rsp_ready;
    logic [2:0]    rsp_coh_msg;
    logic [AW-1:0] rsp_addr;
    logic [LB-1:0] rsp_line;
    logic [WPL-1:0] rsp_word_mask;
    logic          busy;

    int checks = 0;
    int errors = 0;

    l2_home_responder #(.LINE_ADDR_BITS(AW), .WORDS_PER_LINE(WPL), .IDX_BITS(IB), .RSP_LAT(RL)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_coh_msg(req_coh_msg),
        .req_addr(req_addr), .req_line(req_line), .req_word_mask(req_word_mask),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_coh_msg(rsp_coh_msg),
        .rsp_addr(rsp_addr), .rsp_line(rsp_line), .rsp_word_mask(rsp_word_mask),
        .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, actual timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [LB-1:0] act, input logic [LB-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h", name, act, exp);
        end
    endtask

    // Behavioural store model: one slot per index holding the full address it was written from.
    bit          m_valid [64];
    int          m_addr  [64];
    logic [LB-1:0] m_data [64];
    bit          m_owner [64];

    function automatic void model_reset();
        for (int i = 0; i < 64; i++) begin
            m_valid[i] = 0;
            m_owner[i] = 0;
        end
    endfunction

    function automatic void model(input logic [2:0] msg, input int addr, input logic [LB-1:0] line,
                                  input logic [WPL-1:0] mask, output logic [2:0] emsg,
                                  output logic [LB-1:0] eline);
        int slot = addr % 64;
        logic [LB-1:0] cur = (m_valid[slot] && m_addr[slot] == addr) ? m_data[slot] : '0;
        emsg  = msg;
        eline = '0;
        case (msg)
            3'd0, 3'd1: eline = cur;
            3'd5: begin eline = cur; m_owner[slot] = 1; end
            3'd3: m_owner[slot] = 1;
            3'd2, 3'd4: begin
                for (int w = 0; w < WPL; w++)
                    if (mask[w]) cur[32*w +: 32] = line[32*w +: 32];
                m_data[slot]  = cur;
                m_addr[slot]  = addr;
                m_valid[slot] = 1;
                if (msg == 3'd4) m_owner[slot] = 0;
            end
            default: emsg = 3'd7;
        endcase
    endfunction

    task automatic run_txn(input string nm, input logic [2:0] msg, input logic [AW-1:0] addr,
                           input logic [LB-1:0] line, input logic [WPL-1:0] mask, input int hold,
                           input logic [2:0] emsg, input logic [LB-1:0] eline);
        int n;
        bit ok;
        @(negedge clk);
        req_coh_msg   = msg;
        req_addr      = addr;
        req_line      = line;
        req_word_mask = mask;
        req_valid     = 1'b1;
        chk({nm, ".req_ready"}, req_ready, 1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        req_line = ~line;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid && n < 40);
        chk({nm, ".latency"}, n, LAT);
        chk({nm, ".msg"}, rsp_coh_msg, emsg);
        chk({nm, ".line"}, rsp_line, eline);
        chk({nm, ".addr"}, rsp_addr, addr);
        chk({nm, ".mask"}, rsp_word_mask, mask);
        ok = 1;
        repeat (hold) begin
            @(negedge clk);
            if (!rsp_valid || rsp_coh_msg !== emsg || rsp_line !== eline || rsp_addr !== addr ||
                rsp_word_mask !== mask || req_ready !== 1'b0) ok = 0;
        end
        if (hold > 0) chk({nm, ".hold_stable"}, ok, 1);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        chk({nm, ".idle_after"}, {rsp_valid, req_ready, busy}, 3'b010);
    endtask

    typedef struct {
        logic [2:0]     msg;
        logic [AW-1:0]  addr;
        logic [LB-1:0]  line;
        logic [WPL-1:0] mask;
        int             hold;
        logic [2:0]     exp_msg;
        logic [LB-1:0]  exp_line;
    } vec_t;

    localparam logic [LB-1:0] L_DCBA = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
    localparam logic [LB-1:0] L_C0A  = 128'h00000000_CCCCCCCC_00000000_AAAAAAAA;
    localparam logic [LB-1:0] L1     = 128'h12345678_9ABCDEF0_0FEDCBA9_87654321;
    localparam logic [LB-1:0] L2     = 128'h11111111_22222222_33333333_44444444;

    vec_t vt [17];

    initial begin
        logic [2:0]     emsg, rmsg;
        logic [LB-1:0]  eline, rline;
        logic [AW-1:0]  raddr;
        logic [WPL-1:0] rmask;
        int             slot;

        vt[0]  = '{3'd0, 28'h40, '0,     4'hF, 0, 3'd0, '0};
        vt[1]  = '{3'd2, 28'h40, L_DCBA, 4'h5, 1, 3'd2, '0};
        vt[2]  = '{3'd1, 28'h40, '0,     4'hF, 0, 3'd1, L_C0A};
        vt[3]  = '{3'd4, 28'h41, L1,     4'hF, 0, 3'd4, '0};
        vt[4]  = '{3'd5, 28'h41, '0,     4'hF, 5, 3'd5, L1};
        vt[5]  = '{3'd4, 28'h40, L2,     4'hF, 2, 3'd4, '0};
        vt[6]  = '{3'd0, 28'h80, '0,     4'hF, 0, 3'd0, '0};
        vt[7]  = '{3'd0, 28'h40, '0,     4'hF, 0, 3'd0, L2};
        vt[8]  = '{3'd6, 28'h40, '1,     4'hF, 0, 3'd7, '0};
        vt[9]  = '{3'd0, 28'h40, '0,     4'hF, 0, 3'd0, L2};
        vt[10] = '{3'd7, 28'h40, '1,     4'hF, 1, 3'd7, '0};
        vt[11] = '{3'd2, 28'h80, L1,     4'h0, 0, 3'd2, '0};
        vt[12] = '{3'd0, 28'h40, '0,     4'hF, 0, 3'd0, '0};
        vt[13] = '{3'd1, 28'h80, '0,     4'h0, 0, 3'd1, '0};
        vt[14] = '{3'd3, 28'h41, L2,     4'hF, 0, 3'd3, '0};
        vt[15] = '{3'd3, 28'h41, '0,     4'hF, 3, 3'd3, '0};
        vt[16] = '{3'd5, 28'h41, '0,     4'h0, 0, 3'd5, L1};

        rst = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        req_coh_msg = '0;
        req_addr = '0;
        req_line = '0;
        req_word_mask = '0;
        repeat (2) @(negedge clk);
        chk("reset.ctrl", {req_ready, rsp_valid, busy}, 3'b100);
        chk("reset.rsp_msg", rsp_coh_msg, 0);
        chk("reset.rsp_line", rsp_line, 0);
        chk("reset.rsp_addr_mask", {rsp_addr, rsp_word_mask}, 0);
        rst = 1'b1;

        for (int i = 0; i < 17; i++)
            run_txn($sformatf("vec%0d", i), vt[i].msg, vt[i].addr, vt[i].line, vt[i].mask,
                    vt[i].hold, vt[i].exp_msg, vt[i].exp_line);
        chk("owner_after_reqo", dut.owner_q[1], 1);

        // Reset while waiting: pending response dropped, outputs back to reset values at once.
        @(negedge clk);
        req_coh_msg = 3'd0; req_addr = 28'h41; req_word_mask = 4'hF; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("midrst.busy_in_wait", busy, 1);
        #1 rst = 1'b0;
        #1;
        chk("midrst.ctrl", {rsp_valid, req_ready, busy}, 3'b010);
        chk("midrst.rsp_fields", {rsp_coh_msg, rsp_line, rsp_word_mask}, 0);
        chk("midrst.owner", dut.owner_q[1], 0);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        run_txn("post_rst_read", 3'd0, 28'h41, '0, 4'hF, 0, 3'd0, '0);

        for (int t = 0; t < 80; t++) begin
            rmsg  = 3'($urandom_range(0, 7));
            raddr = AW'($urandom_range(0, 3) * 64 + $urandom_range(0, 3));
            rline = {$urandom, $urandom, $urandom, $urandom};
            rmask = 4'($urandom_range(0, 15));
            model(rmsg, int'(raddr), rline, rmask, emsg, eline);
            run_txn($sformatf("rnd%0d", t), rmsg, raddr, rline, rmask,
                    $urandom_range(0, 3), emsg, eline);
            slot = int'(raddr) % 64;
            chk($sformatf("rnd%0d.owner", t), dut.owner_q[slot], m_owner[slot]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/l2_home_responder.md
Name: l2_home_responder

Overview:
- Home-side responder for the Spandex L2 request channel. Accepts L2 outgoing requests (ReqV, ReqS, ReqWT, ReqO, ReqWB, ReqOdata), services them from a small direct-mapped line store, and returns the matching response on the L2 response-in channel.
- Used as the LLC stand-in for L2 unit/integration benches, and as the baseline for a later full LLC.
- Forwards and invalidations are out of scope. It never drives the fwd channel.

Parameters:
- LINE_ADDR_BITS, 28, width of line address.
- WORDS_PER_LINE, 4, 32-bit words per line; the line is 32*WORDS_PER_LINE bits.
- IDX_BITS, 6, line-store index bits, giving 2^IDX_BITS entries.
- RSP_LAT, 2, extra wait cycles between request capture and response valid; legal range 0..15.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- req_valid  in  1  L2 request valid.
- req_ready  out  1  responder can accept a request.
- req_coh_msg  in  3  request code: 0 ReqV, 1 ReqS, 2 ReqWT, 3 ReqO, 4 ReqWB, 5 ReqOdata; 6 and 7 are illegal.
- req_addr  in  LINE_ADDR_BITS  line address.
- req_line  in  32*WORDS_PER_LINE  write data.
- req_word_mask  in  WORDS_PER_LINE  words targeted.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  L2 accepts the response.
- rsp_coh_msg  out  3  response code: 0 RspV, 1 RspS, 2 RspWTAck, 3 RspO, 4 RspWBAck, 5 RspOdata, 7 RspNack.
- rsp_addr  out  LINE_ADDR_BITS  echoes the request address.
- rsp_line  out  32*WORDS_PER_LINE  read data; zero for acks.
- rsp_word_mask  out  WORDS_PER_LINE  echoes the request mask.
- busy  out  1  FSM is not in IDLE.

Behaviour:
- Interface: one clock `clk`; reset `rst` is asynchronous and active-low.
- Reset values:
  - FSM state IDLE; req_ready=1; rsp_valid=0; busy=0.
  - All rsp_* data outputs 0.
  - Wait counter 0.
  - All entry valid bits and owner bits 0.
  - Line-store data array is not reset.
- Entry index: idx = req_addr[IDX_BITS-1:0]. A tag of the remaining upper address bits is stored per entry.
- Entry hit: the entry's valid bit is 1 and its stored tag equals the request tag.
- A read that misses returns an all-zero line. The entry is not allocated.
- States: IDLE, EXEC, WAIT, SEND.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, register coh_msg, addr, line and mask, then go to EXEC.
  - No other state accepts a request; req_ready=0 outside IDLE.
- EXEC (exactly one cycle). Performs the store access and forms the response:
  - ReqV and ReqS: rsp_line = the hit line, or 0 on a miss. Response code RspV or RspS.
  - ReqO and ReqOdata:
    - Set the entry's owner bit.
    - ReqOdata returns the line with RspOdata.
    - ReqO returns rsp_line=0 with RspO.
  - ReqWT:
    - Merge the masked 32-bit words into the entry. On a miss, allocate the entry: unmasked words become 0, the tag is written and valid is set.
    - Response RspWTAck.
  - ReqWB:
    - Perform the same masked merge and allocate.
    - Clear the owner bit.
    - Response RspWBAck.
  - Illegal code: no store change; respond RspNack.
  - A mask of all zeros is legal:
    - Reads return the data anyway.
    - Writes change no data but still allocate.
  - Then go to WAIT if RSP_LAT>0, otherwise to SEND.
- WAIT:
  - The counter loads RSP_LAT-1 on entry and decrements every cycle.
  - Leave for SEND in the cycle the counter reads 0.
  - Total latency from the request handshake cycle to the first rsp_valid cycle is 2+RSP_LAT cycles.
- SEND:
  - rsp_valid=1.
  - All rsp_* outputs are held stable until rsp_ready.
  - On rsp_valid&&rsp_ready, go to IDLE.
  - A new request can be accepted no earlier than the cycle after the response handshake. There is no back-to-back overlap.
- Ordering: strictly one outstanding transaction; responses come back in request order.
- Read-after-write to the same line returns the merged data.
- Ownership:
  - An owner bit that is already set is not checked; a second ReqO still succeeds.
  - The owner bit is observable only through verification hierarchy.
- Reset mid-operation: a pending response is dropped, and outputs return to their reset values immediately (asynchronous). Store data written before reset persists, but it is invisible because all valid bits are cleared.
- Index aliasing: a write to a different tag at the same idx overwrites the entry. A subsequent read of the old address misses and returns 0.

Test Plan:
- Reset, then ReqV addr 0x0000040 mask 4'b1111 -> RspV, line 0, addr echoed, rsp_valid first high 4 cycles after the handshake (RSP_LAT=2).
- ReqWT addr 0x40 mask 4'b0101 line {0xDDDD_DDDD,0xCCCC_CCCC,0xBBBB_BBBB,0xAAAA_AAAA}, then ReqS addr 0x40 -> RspWTAck, then RspS line {0,0xCCCC_CCCC,0,0xAAAA_AAAA}.
- ReqOdata addr 0x41 after ReqWB full line 0x1234..., with rsp_ready held low 5 cycles -> RspOdata held stable with identical fields for all 6 valid cycles; req_ready stays 0 throughout.
- ReqWB addr 0x40 then ReqV addr 0x80 (same idx, different tag) then ReqV addr 0x40 -> RspWBAck, RspV line 0, RspV with the WB data.
- req_coh_msg=6 -> RspNack, rsp_line 0, store unchanged on a subsequent read.
- Assert rst low while in WAIT -> rsp_valid=0 and req_ready=1 within the same cycle; a following ReqV returns 0.
